// File: rtl/mux2to1_32_pkg.sv
// Shared constants for the next-PC word selector.
// Default data width and the select encodings used by the mux and its bench.
package mux2to1_32_pkg;

  localparam int   MUX_WIDTH = 32;
  localparam logic SEL_IN0   = 1'b0;
  localparam logic SEL_IN1   = 1'b1;

endpackage

// File: rtl/mux2to1_32_if.sv
// Bus bundle for the 2:1 word selector: select, data inputs, enable and both output views.
// Master drives sel/in0/in1/en; slave (the mux) returns out, out_q and sel_q.
interface mux2to1_32_if
  import mux2to1_32_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH
);

  logic             sel;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             en;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             sel_q;

  modport master (
    output sel, in0, in1, en,
    input  out, out_q, sel_q
  );

  modport slave (
    input  sel, in0, in1, en,
    output out, out_q, sel_q
  );

endinterface

// File: rtl/mux2to1_32_reg.sv
// Enable register for the selected word and its select bit; 1-cycle latency.
// No backpressure: en=0 holds, async active-low reset loads RESET_VAL and clears sel_q.
module mux2to1_32_reg
  import mux2to1_32_pkg::*;
#(
  parameter int               WIDTH     = MUX_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             sel_d,
  output logic [WIDTH-1:0] q,
  output logic             sel_q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q     <= RESET_VAL;
      sel_q <= SEL_IN0;
    end else if (en) begin
      q     <= d;
      sel_q <= sel_d;
    end
  end

endmodule

// File: rtl/mux2to1_32.sv
// IF-stage next-PC mux: out is combinational (0 cycles), out_q/sel_q a registered copy (1 cycle).
// No backpressure; en=0 holds the registered copy, out stays live through reset.
module mux2to1_32
  import mux2to1_32_pkg::*;
#(
  parameter int               WIDTH     = MUX_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  mux2to1_32_if.slave  bus
);

  logic [WIDTH-1:0] sel_word;

  // Only an explicit 1 picks in1; an unknown select falls through to PC+4.
  always_comb begin
    sel_word = bus.in0;
    case (bus.sel)
      SEL_IN1: sel_word = bus.in1;
      default: sel_word = bus.in0;
    endcase
  end

  assign bus.out = sel_word;

  mux2to1_32_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_reg (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.en),
    .d     (sel_word),
    .sel_d (bus.sel),
    .q     (bus.out_q),
    .sel_q (bus.sel_q)
  );

endmodule

// File: tb/tb_mux2to1_32.sv
// Randomized and directed bench for mux2to1_32 against a behavioural select/register model.
module tb_mux2to1_32;

  logic clk = 1'b0;
  logic rst;
  int   errs   = 0;
  int   checks = 0;

  logic [31:0] exp_q;
  logic        exp_sel_q;

  mux2to1_32_if bus ();

  mux2to1_32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic s, input logic [31:0] a, input logic [31:0] b);
    return (s === 1'b1) ? b : a;
  endfunction

  task automatic chk_out(input string tag);
    chk(tag, bus.out, pick(bus.sel, bus.in0, bus.in1));
  endtask

  // One clock: update the model at the edge, compare registered outputs just after it.
  task automatic tick();
    @(posedge clk);
    if (rst && bus.en) begin
      exp_q     = pick(bus.sel, bus.in0, bus.in1);
      exp_sel_q = bus.sel;
    end
    #1;
    chk("out_q", bus.out_q, exp_q);
    chk("sel_q", {31'd0, bus.sel_q}, {31'd0, exp_sel_q});
    @(negedge clk);
  endtask

  task automatic async_reset_check(input string tag);
    rst = 1'b0;
    #1;
    exp_q     = 32'd0;
    exp_sel_q = 1'b0;
    chk({tag, "_out_q"}, bus.out_q, exp_q);
    chk({tag, "_sel_q"}, {31'd0, bus.sel_q}, 32'd0);
    chk({tag, "_out"}, bus.out, pick(bus.sel, bus.in0, bus.in1));
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] held_q;
    logic        held_sel;

    rst     = 1'b0;
    bus.sel = 1'b0;
    bus.in0 = 32'h0;
    bus.in1 = 32'h0;
    bus.en  = 1'b0;
    exp_q     = 32'd0;
    exp_sel_q = 1'b0;
    #2;
    chk("rst_out_q", bus.out_q, 32'd0);
    chk("rst_sel_q", {31'd0, bus.sel_q}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Combinational select with no clock edge
    bus.in0 = 32'h0000_0004;
    bus.in1 = 32'h0000_0100;
    bus.sel = 1'b0;
    #1 chk("sel0_out", bus.out, 32'h0000_0004);
    bus.sel = 1'b1;
    #1 chk("sel1_out", bus.out, 32'h0000_0100);

    // Enabled capture; old value visible until the edge
    bus.en  = 1'b1;
    bus.in1 = 32'hDEAD_BEEF;
    #1 chk("pre_edge_q", bus.out_q, 32'd0);
    tick();
    chk("cap_q", bus.out_q, 32'hDEAD_BEEF);
    chk("cap_sel_q", {31'd0, bus.sel_q}, 32'd1);

    // Hold for three edges while the inputs keep moving
    bus.en   = 1'b0;
    held_q   = bus.out_q;
    held_sel = bus.sel_q;
    for (int i = 0; i < 3; i++) begin
      bus.sel = ~bus.sel;
      bus.in0 = $urandom;
      bus.in1 = $urandom;
      #1 chk_out("hold_out");
      tick();
      chk("hold_q", bus.out_q, held_q);
      chk("hold_sel_q", {31'd0, bus.sel_q}, {31'd0, held_sel});
    end

    // Async reset mid-stream, then first capture after release
    bus.en  = 1'b1;
    bus.sel = 1'b1;
    bus.in0 = 32'hA5A5_0001;
    bus.in1 = 32'h5A5A_0002;
    tick();
    async_reset_check("midrst");
    tick();
    chk("post_rst_q", bus.out_q, 32'h5A5A_0002);

    // Unknown select defaults to in0; in1 matches so a 2-state simulator agrees too
    bus.in0 = 32'h1234_5678;
    bus.in1 = 32'h1234_5678;
    bus.sel = 1'bx;
    #1 chk("selx_out", bus.out, 32'h1234_5678);
    bus.sel = 1'b0;

    // Walking-1 pass-through on both legs
    for (int i = 0; i < 32; i++) begin
      bus.in0 = 32'd1 << i;
      bus.in1 = 32'd1 << (31 - i);
      bus.sel = 1'b0;
      #1 chk("walk_sel0", bus.out, 32'd1 << i);
      bus.sel = 1'b1;
      #1 chk("walk_sel1", bus.out, 32'd1 << (31 - i));
    end

    // Random traffic with occasional async reset pulses
    for (int n = 0; n < 300; n++) begin
      bus.sel = 1'($urandom_range(1));
      bus.in0 = $urandom;
      bus.in1 = $urandom;
      bus.en  = ($urandom_range(3) != 0);
      if ($urandom_range(31) == 0) async_reset_check("rnd_rst");
      #1 chk_out("rnd_out");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
